// File: rtl/audio_src_arb.sv
// Two-source stereo frame arbiter: one-entry output register, pop-free source switching with a
// zero-filled gap, mute, and an output frame counter. Optional: AUDIO_SRC_ARB_DISCARD_EN.
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | forwarding the selected source; a pending switch fires on a non-accept cycle
// GAP   | new source selected; its next gap_cnt accepted frames go out as zeros
module audio_src_arb #(
    parameter int width_p      = 24,
    parameter int gap_frames_p = 4,
    parameter int cnt_width_p  = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   s0_valid_i,
    output logic                   s0_ready_o,
    input  logic [width_p-1:0]     s0_left_i,
    input  logic [width_p-1:0]     s0_right_i,
    input  logic                   s1_valid_i,
    output logic                   s1_ready_o,
    input  logic [width_p-1:0]     s1_left_i,
    input  logic [width_p-1:0]     s1_right_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [width_p-1:0]     left_o,
    output logic [width_p-1:0]     right_o,
    input  logic                   sel_req_i,
    input  logic                   mute_req_i,
    output logic                   sel_o,
    output logic                   mute_o,
    output logic                   gap_o,
    output logic [cnt_width_p-1:0] frames_o
);

    localparam int gcw_lp = (gap_frames_p > 0) ? $clog2(gap_frames_p + 1) : 1;

    typedef enum logic {
        st_run = 1'b0,
        st_gap = 1'b1
    } state_e;

    state_e                  state_r, state_n;
    logic                    sel_r, sel_n;
    logic                    pend_r, pend_n;
    logic [gcw_lp-1:0]       gap_cnt_r, gap_cnt_n;
    logic                    mute_r;
    logic                    valid_r;
    logic [width_p-1:0]      left_r, right_r;
    logic [cnt_width_p-1:0]  frames_r;

    logic                    load;
    logic                    sel_valid;
    logic                    acc;
    logic                    zero_fill;
    logic [width_p-1:0]      sel_left, sel_right;

    assign load      = ~valid_r | ready_i;
    assign sel_valid = sel_r ? s1_valid_i : s0_valid_i;
    assign sel_left  = sel_r ? s1_left_i  : s0_left_i;
    assign sel_right = sel_r ? s1_right_i : s0_right_i;
    assign acc       = sel_valid & load;
    assign zero_fill = mute_r | (state_r == st_gap);

`ifdef AUDIO_SRC_ARB_DISCARD_EN
    // Unselected source is drained and dropped so line-in never stalls upstream.
    assign s0_ready_o = sel_r ? 1'b1 : load;
    assign s1_ready_o = sel_r ? load : 1'b1;
`else
    assign s0_ready_o = ~sel_r & load;
    assign s1_ready_o = sel_r & load;
`endif

    always_comb begin
        state_n   = state_r;
        sel_n     = sel_r;
        pend_n    = pend_r;
        gap_cnt_n = gap_cnt_r;
        unique case (state_r)
            st_run: begin
                // Switch only between frames, so an accept always wins over a pending switch.
                if (pend_r && !acc) begin
                    sel_n     = ~sel_r;
                    pend_n    = 1'b0;
                    gap_cnt_n = gcw_lp'(gap_frames_p);
                    if (gap_frames_p != 0) begin
                        state_n = st_gap;
                    end
                end else if (sel_req_i) begin
                    pend_n = 1'b1;
                end
            end
            st_gap: begin
                if (acc) begin
                    gap_cnt_n = gap_cnt_r - gcw_lp'(1);
                    if (gap_cnt_r == gcw_lp'(1)) begin
                        state_n = st_run;
                    end
                end
            end
            default: state_n = st_run;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= st_run;
            sel_r     <= 1'b0;
            pend_r    <= 1'b0;
            gap_cnt_r <= '0;
            mute_r    <= 1'b0;
            valid_r   <= 1'b0;
            left_r    <= '0;
            right_r   <= '0;
            frames_r  <= '0;
        end else begin
            state_r   <= state_n;
            sel_r     <= sel_n;
            pend_r    <= pend_n;
            gap_cnt_r <= gap_cnt_n;
            if (mute_req_i) begin
                mute_r <= ~mute_r;
            end
            if (acc) begin
                valid_r <= 1'b1;
                left_r  <= zero_fill ? '0 : sel_left;
                right_r <= zero_fill ? '0 : sel_right;
            end else if (ready_i) begin
                valid_r <= 1'b0;
            end
            if (valid_r && ready_i) begin
                frames_r <= frames_r + cnt_width_p'(1);
            end
        end
    end

    assign valid_o  = valid_r;
    assign left_o   = left_r;
    assign right_o  = right_r;
    assign sel_o    = sel_r;
    assign mute_o   = mute_r;
    assign gap_o    = (state_r == st_gap);
    assign frames_o = frames_r;

endmodule

// File: tb/tb_audio_src_arb.sv
// Scoreboard bench for audio_src_arb: a frame-level reference model queues expected output
// frames at input accept and compares them at output handshake; scenario tasks add spot checks.
module tb_audio_src_arb;

    localparam int W          = 24;
    localparam int GAP_FRAMES = 4;
    localparam int CW         = 16;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          s0_valid_i = 1'b0, s1_valid_i = 1'b0;
    logic          s0_ready_o, s1_ready_o;
    logic [W-1:0]  s0_left_i = '0, s0_right_i = '0, s1_left_i = '0, s1_right_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [W-1:0]  left_o, right_o;
    logic          sel_req_i = 1'b0, mute_req_i = 1'b0;
    logic          sel_o, mute_o, gap_o;
    logic [CW-1:0] frames_o;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] sb_q[$];
    logic           mon_en = 1'b0;
    logic           m_valid = 1'b0, m_sel = 1'b0, m_mute = 1'b0, m_pend = 1'b0;
    int             m_gap = 0;
    logic [CW-1:0]  m_frames = '0;

    audio_src_arb #(.width_p(W), .gap_frames_p(GAP_FRAMES), .cnt_width_p(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s0_valid_i(s0_valid_i), .s0_ready_o(s0_ready_o), .s0_left_i(s0_left_i), .s0_right_i(s0_right_i),
        .s1_valid_i(s1_valid_i), .s1_ready_o(s1_ready_o), .s1_left_i(s1_left_i), .s1_right_i(s1_right_i),
        .valid_o(valid_o), .ready_i(ready_i), .left_o(left_o), .right_o(right_o),
        .sel_req_i(sel_req_i), .mute_req_i(mute_req_i),
        .sel_o(sel_o), .mute_o(mute_o), .gap_o(gap_o), .frames_o(frames_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // One clock cycle: model and scoreboard update at the falling edge, stimulus may change
    // 1 time unit after the following rising edge.
    task automatic tick();
        logic           exp_load, sv, acc, exp_r0, exp_r1;
        logic [2*W-1:0] exp_frame, sel_data;
        @(negedge clk_i);
        if (reset_i) begin
            sb_q.delete();
            m_valid = 1'b0; m_sel = 1'b0; m_mute = 1'b0; m_pend = 1'b0;
            m_gap = 0; m_frames = '0;
        end else if (mon_en) begin
            exp_load = !m_valid || ready_i;
            sv       = m_sel ? s1_valid_i : s0_valid_i;
            acc      = sv && exp_load;
`ifdef AUDIO_SRC_ARB_DISCARD_EN
            exp_r0 = m_sel ? 1'b1 : exp_load;
            exp_r1 = m_sel ? exp_load : 1'b1;
`else
            exp_r0 = !m_sel && exp_load;
            exp_r1 = m_sel && exp_load;
`endif
            total++;
            if ({valid_o, s0_ready_o, s1_ready_o} !== {m_valid, exp_r0, exp_r1}) begin
                bad++;
                $display("FAIL hs_flags {valid,r0,r1} got %b expected %b at %0t",
                         {valid_o, s0_ready_o, s1_ready_o}, {m_valid, exp_r0, exp_r1}, $time);
            end
            total++;
            if ({sel_o, mute_o, gap_o} !== {m_sel, m_mute, (m_gap != 0)}) begin
                bad++;
                $display("FAIL status {sel,mute,gap} got %b expected %b at %0t",
                         {sel_o, mute_o, gap_o}, {m_sel, m_mute, (m_gap != 0)}, $time);
            end
            total++;
            if (frames_o !== m_frames) begin
                bad++;
                $display("FAIL frames_cnt got %h expected %h at %0t", frames_o, m_frames, $time);
            end
            if (m_valid && ready_i) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty got frame %h expected none at %0t", {left_o, right_o}, $time);
                end else begin
                    exp_frame = sb_q.pop_front();
                    if ({left_o, right_o} !== exp_frame) begin
                        bad++;
                        $display("FAIL sb_data got %h expected %h at %0t", {left_o, right_o}, exp_frame, $time);
                    end
                end
                m_frames++;
            end
            if (acc) begin
                sel_data = m_sel ? {s1_left_i, s1_right_i} : {s0_left_i, s0_right_i};
                sb_q.push_back((m_mute || m_gap != 0) ? '0 : sel_data);
            end
            m_valid = acc ? 1'b1 : (ready_i ? 1'b0 : m_valid);
            if (m_gap != 0) begin
                if (acc) m_gap--;
            end else if (m_pend && !acc) begin
                m_sel  = !m_sel;
                m_pend = 1'b0;
                m_gap  = GAP_FRAMES;
            end else if (sel_req_i) begin
                m_pend = 1'b1;
            end
            if (mute_req_i) m_mute = !m_mute;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        mon_en  = 1'b1;
        total++;
        if ({valid_o, left_o, right_o, sel_o, mute_o, gap_o, frames_o} !== '0) begin
            bad++;
            $display("FAIL reset_vals got v=%b l=%h r=%h sel=%b mute=%b gap=%b fr=%h expected all 0",
                     valid_o, left_o, right_o, sel_o, mute_o, gap_o, frames_o);
        end
    endtask

    task automatic test_stream();
        logic [CW-1:0] f0;
        f0 = frames_o;
        ready_i = 1'b1;
        s0_valid_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            s0_left_i  = W'(i);
            s0_right_i = W'(i + 1);
            tick();
            total++;
            if (valid_o !== 1'b1 || left_o !== W'(i) || right_o !== W'(i + 1)) begin
                bad++;
                $display("FAIL stream_latency frame %0d got v=%b l=%h r=%h expected v=1 l=%h r=%h",
                         i, valid_o, left_o, right_o, W'(i), W'(i + 1));
            end
        end
        s0_valid_i = 1'b0;
        tick();
        tick();
        total++;
        if (frames_o !== f0 + CW'(20) || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stream_count got frames=%h valid=%b expected frames=%h valid=0",
                     frames_o, valid_o, f0 + CW'(20));
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b1;
        s0_valid_i = 1'b1;
        s0_left_i = 24'h0000AA; s0_right_i = 24'h0000AB;
        tick();
        ready_i = 1'b0;
        s0_left_i = 24'h0000BB; s0_right_i = 24'h0000BC;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (valid_o !== 1'b1 || left_o !== 24'h0000AA || right_o !== 24'h0000AB || s0_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cycle %0d got v=%b l=%h r=%h rdy=%b expected v=1 l=0000aa r=0000ab rdy=0",
                         i, valid_o, left_o, right_o, s0_ready_o);
            end
        end
        ready_i = 1'b1;
        tick();
        total++;
        if (valid_o !== 1'b1 || left_o !== 24'h0000BB) begin
            bad++;
            $display("FAIL stall_release got v=%b l=%h expected v=1 l=0000bb", valid_o, left_o);
        end
        s0_valid_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_switch();
        ready_i = 1'b1;
        s0_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s0_left_i = W'(24'h050000 + i); s0_right_i = W'(24'h060000 + i);
            sel_req_i = (i == 2);
            tick();
        end
        sel_req_i = 1'b0;
        total++;
        if (sel_o !== 1'b0 || gap_o !== 1'b0) begin
            bad++;
            $display("FAIL switch_deferred got sel=%b gap=%b expected sel=0 gap=0", sel_o, gap_o);
        end
        s0_valid_i = 1'b0;
        tick();
        total++;
        if (sel_o !== 1'b1 || gap_o !== 1'b1) begin
            bad++;
            $display("FAIL switch_fire got sel=%b gap=%b expected sel=1 gap=1", sel_o, gap_o);
        end
        s1_valid_i = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            s1_left_i = W'(24'h100000 + j); s1_right_i = W'(24'h200000 + j);
            sel_req_i = (j == 2);
            tick();
            total++;
            if (j <= GAP_FRAMES) begin
                if (valid_o !== 1'b1 || left_o !== '0 || right_o !== '0 || gap_o !== (j < GAP_FRAMES)) begin
                    bad++;
                    $display("FAIL gap_zero %0d got v=%b l=%h r=%h gap=%b expected v=1 l=0 r=0 gap=%b",
                             j, valid_o, left_o, right_o, gap_o, (j < GAP_FRAMES));
                end
            end else if (valid_o !== 1'b1 || left_o !== W'(24'h100000 + j) || gap_o !== 1'b0) begin
                bad++;
                $display("FAIL gap_after %0d got v=%b l=%h gap=%b expected v=1 l=%h gap=0",
                         j, valid_o, left_o, gap_o, W'(24'h100000 + j));
            end
        end
        sel_req_i = 1'b0;
        s1_valid_i = 1'b0;
        tick();
        tick();
        total++;
        if (sel_o !== 1'b1) begin
            bad++;
            $display("FAIL gap_req_ignored got sel=%b expected sel=1", sel_o);
        end
    endtask

    task automatic test_mute();
        logic [W-1:0] want;
        ready_i = 1'b1;
        s1_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s1_left_i = W'(24'h300000 + k); s1_right_i = W'(24'h400000 + k);
            mute_req_i = (k == 1 || k == 4);
            tick();
            want = (k >= 2 && k <= 4) ? '0 : W'(24'h300000 + k);
            total++;
            if (valid_o !== 1'b1 || left_o !== want || mute_o !== (k >= 1 && k <= 3)) begin
                bad++;
                $display("FAIL mute_frame %0d got v=%b l=%h mute=%b expected v=1 l=%h mute=%b",
                         k, valid_o, left_o, mute_o, want, (k >= 1 && k <= 3));
            end
        end
        mute_req_i = 1'b1;
        sel_req_i  = 1'b1;
        tick();
        mute_req_i = 1'b0;
        sel_req_i  = 1'b0;
        s1_valid_i = 1'b0;
        tick();
        total++;
        if (sel_o !== 1'b0 || mute_o !== 1'b1 || gap_o !== 1'b1) begin
            bad++;
            $display("FAIL simul_req got sel=%b mute=%b gap=%b expected sel=0 mute=1 gap=1", sel_o, mute_o, gap_o);
        end
    endtask

    task automatic test_reset_midframe();
        ready_i = 1'b1;
        s0_valid_i = 1'b1;
        s0_left_i = 24'h0A0A0A; s0_right_i = 24'h0B0B0B;
        tick();
        ready_i = 1'b0;
        tick();
        total++;
        if (valid_o !== 1'b1) begin
            bad++;
            $display("FAIL midframe_held got v=%b expected v=1", valid_o);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        s0_valid_i = 1'b0;
        total++;
        if ({valid_o, sel_o, mute_o, gap_o, frames_o} !== '0) begin
            bad++;
            $display("FAIL midframe_reset got v=%b sel=%b mute=%b gap=%b fr=%h expected all 0",
                     valid_o, sel_o, mute_o, gap_o, frames_o);
        end
        ready_i = 1'b1;
        tick();
    endtask

    task automatic test_unselected();
        logic want_rdy;
`ifdef AUDIO_SRC_ARB_DISCARD_EN
        want_rdy = 1'b1;
`else
        want_rdy = 1'b0;
`endif
        ready_i = 1'b1;
        s1_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s1_left_i = W'(24'h700000 + i); s1_right_i = W'(24'h710000 + i);
            tick();
            total++;
            if (s1_ready_o !== want_rdy || valid_o !== 1'b0 || sel_o !== 1'b0) begin
                bad++;
                $display("FAIL unsel_s1 got rdy=%b v=%b sel=%b expected rdy=%b v=0 sel=0",
                         s1_ready_o, valid_o, sel_o, want_rdy);
            end
        end
        s1_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        ready_i = 1'b1;
        s0_valid_i = 1'b1;
        for (int i = 1; i <= 65537; i++) begin
            s0_left_i = W'(i); s0_right_i = W'(i ^ 24'hFFFFFF);
            tick();
            if (i == 65536) begin
                total++;
                if (frames_o !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL wrap_pre got %h expected ffff", frames_o);
                end
            end
        end
        total++;
        if (frames_o !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_post got %h expected 0000", frames_o);
        end
        s0_valid_i = 1'b0;
        tick();
        tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_switch();
        test_mute();
        test_reset_midframe();
        test_unselected();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
